// File: rtl/alu_ex_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_ex_stage_pkg
//   Shared definitions for the TSC CPU execute stage. The ALU control decoder
//   and the execute stage both use these definitions.
//   Contents:
//     DEF_WORD_WIDTH     - default datapath width
//     DEF_REG_ADDR_WIDTH - default register-file address width
//     ALU_OP_WIDTH       - width of the ALU operation code
//     alu_op_e           - named ALU operation codes (ALU_ADD .. ALU_NEG)
// -----------------------------------------------------------------------------
package alu_ex_stage_pkg;

  localparam int DEF_WORD_WIDTH     = 16;
  localparam int DEF_REG_ADDR_WIDTH = 2;
  localparam int ALU_OP_WIDTH       = 4;

  // 4'b1011 and 4'b1111 are unassigned; the ALU returns zero for them.
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_PASSA = 4'b0010,
    ALU_NOT   = 4'b0011,
    ALU_AND   = 4'b0100,
    ALU_OR    = 4'b0101,
    ALU_NE    = 4'b0110,
    ALU_EQ    = 4'b0111,
    ALU_GTZ   = 4'b1000,
    ALU_LTZ   = 4'b1001,
    ALU_PASSB = 4'b1010,
    ALU_SHL   = 4'b1100,
    ALU_SHR   = 4'b1101,
    ALU_NEG   = 4'b1110
  } alu_op_e;

endpackage

// File: rtl/alu_ex_stage_alu.sv
// -----------------------------------------------------------------------------
// alu_ex_stage_alu
//   Purely combinational ALU for the execute stage.
//   Ports:
//     alu_op   in  ALU_OP_WIDTH  operation code (alu_op_e values)
//     a, b     in  W             operands
//     result   out W             operation result (compares give 1 / 0)
//     overflow out 1             signed overflow of ADD/SUB, 0 otherwise
// -----------------------------------------------------------------------------
module alu_ex_stage_alu
  import alu_ex_stage_pkg::*;
#(
  parameter int W = DEF_WORD_WIDTH
) (
  input  logic [ALU_OP_WIDTH-1:0] alu_op,
  input  logic [W-1:0]            a,
  input  logic [W-1:0]            b,
  output logic [W-1:0]            result,
  output logic                    overflow
);

  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic [W-1:0] w_true;

  assign w_sum  = a + b;
  assign w_diff = a - b;
  // Compare ops deliver their condition in bit 0 of an otherwise-zero word.
  assign w_true = {{(W-1){1'b0}}, 1'b1};

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        result   = w_sum;
        // Overflow: operands agree in sign but the sum does not.
        overflow = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        result   = w_diff;
        // Overflow: operands differ in sign and the difference takes b's sign.
        overflow = (a[W-1] != b[W-1]) && (w_diff[W-1] != a[W-1]);
      end
      ALU_PASSA: result = a;
      ALU_NOT:   result = ~a;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_NE:    result = (a != b) ? w_true : '0;
      ALU_EQ:    result = (a == b) ? w_true : '0;
      ALU_GTZ:   result = (!a[W-1] && (a != '0)) ? w_true : '0;
      ALU_LTZ:   result = a[W-1] ? w_true : '0;
      ALU_PASSB: result = b;
      ALU_SHL:   result = {a[W-2:0], 1'b0};
      ALU_SHR:   result = {a[W-1], a[W-1:1]};
      // Negating the most negative value wraps back onto itself; no flag.
      ALU_NEG:   result = -a;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_ex_stage.sv
// -----------------------------------------------------------------------------
// alu_ex_stage
//   Execute stage of the pipelined TSC CPU: runs the ALU on the ID/EX
//   operands, resolves branches in the same cycle, and loads the EX/MEM
//   pipeline register.
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     in_valid              ID/EX slot holds a real instruction
//     stall                 MEM stage cannot accept; EX/MEM holds
//     flush                 squash the instruction in EX
//     alu_op                ALU operation code
//     operand_a, operand_b  ALU operands (forwarded / immediate)
//     store_data            data for a store
//     dest_reg              write-back register
//     mem_read, mem_write, reg_write, is_branch   control bits from ID
//     branch_target         precomputed branch destination
//     branch_taken          combinational fetch redirect
//     redirect_pc           redirect address (branch_target)
//     fwd_result            combinational ALU result for EX-to-EX forwarding
//     ex_mem_*              registered EX/MEM pipeline register contents
//
//   Handshake: in_valid marks the ID/EX slot as holding an instruction;
//   stall is the MEM stage's not-ready. An instruction is consumed only on
//   an edge where in_valid=1, stall=0 and flush=0 ("live"). While stall is
//   high the EX/MEM register holds indefinitely and whatever sits in EX is
//   not consumed; a flushed instruction is dropped even when stalled, and
//   upstream does not replay it.
// -----------------------------------------------------------------------------
module alu_ex_stage
  import alu_ex_stage_pkg::*;
#(
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [ALU_OP_WIDTH-1:0]   alu_op,
  input  logic [WORD_WIDTH-1:0]     operand_a,
  input  logic [WORD_WIDTH-1:0]     operand_b,
  input  logic [WORD_WIDTH-1:0]     store_data,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic                      reg_write,
  input  logic                      is_branch,
  input  logic [WORD_WIDTH-1:0]     branch_target,
  output logic                      branch_taken,
  output logic [WORD_WIDTH-1:0]     redirect_pc,
  output logic [WORD_WIDTH-1:0]     fwd_result,
  output logic                      ex_mem_valid,
  output logic                      ex_mem_mem_read,
  output logic                      ex_mem_mem_write,
  output logic                      ex_mem_reg_write,
  output logic [WORD_WIDTH-1:0]     ex_mem_result,
  output logic [WORD_WIDTH-1:0]     ex_mem_store_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_mem_dest_reg,
  output logic                      ex_mem_overflow
);

  logic [WORD_WIDTH-1:0] w_result;
  logic                  w_overflow;
  logic                  w_live;

  logic                      r_valid;
  logic                      r_mem_read;
  logic                      r_mem_write;
  logic                      r_reg_write;
  logic [WORD_WIDTH-1:0]     r_result;
  logic [WORD_WIDTH-1:0]     r_store_data;
  logic [REG_ADDR_WIDTH-1:0] r_dest_reg;
  logic                      r_overflow;

  alu_ex_stage_alu #(
    .W (WORD_WIDTH)
  ) u_alu (
    .alu_op   (alu_op),
    .a        (operand_a),
    .b        (operand_b),
    .result   (w_result),
    .overflow (w_overflow)
  );

  assign w_live = in_valid & ~flush & ~stall;

  // Gating on live means a branch held under stall redirects only on the
  // cycle it actually leaves EX, so each branch redirects exactly once.
  assign branch_taken = ~reset & w_live & is_branch & w_result[0];
  assign redirect_pc  = branch_target;
  assign fwd_result   = w_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_dest_reg   <= '0;
      r_overflow   <= 1'b0;
    end else if (stall) begin
      // Stall wins over flush: hold the whole register.
      r_valid      <= r_valid;
    end else if (flush || !in_valid) begin
      // Bubble: clear the qualifying bits, leave the data fields alone.
      r_valid      <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
    end else begin
      r_valid      <= 1'b1;
      r_mem_read   <= mem_read;
      r_mem_write  <= mem_write;
      r_reg_write  <= reg_write;
      r_result     <= w_result;
      r_store_data <= store_data;
      r_dest_reg   <= dest_reg;
      r_overflow   <= w_overflow;
    end
  end

  assign ex_mem_valid      = r_valid;
  assign ex_mem_mem_read   = r_mem_read;
  assign ex_mem_mem_write  = r_mem_write;
  assign ex_mem_reg_write  = r_reg_write;
  assign ex_mem_result     = r_result;
  assign ex_mem_store_data = r_store_data;
  assign ex_mem_dest_reg   = r_dest_reg;
  assign ex_mem_overflow   = r_overflow;

endmodule

// File: tb/tb_alu_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_ex_stage
//   Self-checking bench for alu_ex_stage: an arithmetic reference model of the
//   ALU and of the EX/MEM register rules, compared on every falling edge,
//   plus directed vectors with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_ex_stage;

  localparam int W  = 16;
  localparam int RW = 2;

  typedef struct packed {
    logic          valid;
    logic          mem_read;
    logic          mem_write;
    logic          reg_write;
    logic          overflow;
    logic [RW-1:0] dest_reg;
    logic [W-1:0]  store_data;
    logic [W-1:0]  result;
  } em_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid, stall, flush;
  logic [3:0]    alu_op;
  logic [W-1:0]  operand_a, operand_b, store_data, branch_target;
  logic [RW-1:0] dest_reg;
  logic          mem_read, mem_write, reg_write, is_branch;
  logic          branch_taken;
  logic [W-1:0]  redirect_pc, fwd_result;
  logic          ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write, ex_mem_reg_write;
  logic [W-1:0]  ex_mem_result, ex_mem_store_data;
  logic [RW-1:0] ex_mem_dest_reg;
  logic          ex_mem_overflow;

  alu_ex_stage #(.WORD_WIDTH(W), .REG_ADDR_WIDTH(RW)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .stall             (stall),
    .flush             (flush),
    .alu_op            (alu_op),
    .operand_a         (operand_a),
    .operand_b         (operand_b),
    .store_data        (store_data),
    .dest_reg          (dest_reg),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .reg_write         (reg_write),
    .is_branch         (is_branch),
    .branch_target     (branch_target),
    .branch_taken      (branch_taken),
    .redirect_pc       (redirect_pc),
    .fwd_result        (fwd_result),
    .ex_mem_valid      (ex_mem_valid),
    .ex_mem_mem_read   (ex_mem_mem_read),
    .ex_mem_mem_write  (ex_mem_mem_write),
    .ex_mem_reg_write  (ex_mem_reg_write),
    .ex_mem_result     (ex_mem_result),
    .ex_mem_store_data (ex_mem_store_data),
    .ex_mem_dest_reg   (ex_mem_dest_reg),
    .ex_mem_overflow   (ex_mem_overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [38:0] act, input logic [38:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Returns {overflow, result} from plain signed/unsigned integer arithmetic.
  function automatic logic [16:0] model_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    int sa, sb, ua, r;
    logic [15:0] res;
    logic ovf;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ua  = int'(a);
    r   = 0;
    res = 16'h0000;
    ovf = 1'b0;
    case (op)
      4'd0:  begin r = sa + sb; res = r[15:0]; ovf = (r > 32767) || (r < -32768); end
      4'd1:  begin r = sa - sb; res = r[15:0]; ovf = (r > 32767) || (r < -32768); end
      4'd2:  res = a;
      4'd3:  res = ~a;
      4'd4:  res = a & b;
      4'd5:  res = a | b;
      4'd6:  res = (a != b) ? 16'd1 : 16'd0;
      4'd7:  res = (a == b) ? 16'd1 : 16'd0;
      4'd8:  res = (sa > 0) ? 16'd1 : 16'd0;
      4'd9:  res = (sa < 0) ? 16'd1 : 16'd0;
      4'd10: res = b;
      4'd12: begin r = ua * 2; res = r[15:0]; end
      4'd13: begin r = sa >>> 1; res = r[15:0]; end
      4'd14: begin r = -sa; res = r[15:0]; end
      default: res = 16'h0000;
    endcase
    return {ovf, res};
  endfunction

  function automatic logic [15:0] model_res(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] t;
    t = model_alu(op, a, b);
    return t[15:0];
  endfunction

  function automatic logic model_ovf(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b);
    logic [16:0] t;
    t = model_alu(op, a, b);
    return t[16];
  endfunction

  em_t m_reg;

  // EX/MEM contents the stage must hold after the coming edge.
  function automatic em_t model_next(input em_t cur);
    em_t n;
    n = cur;
    if (reset) n = '0;
    else if (stall) n = cur;
    else if (flush || !in_valid) begin
      n.valid     = 1'b0;
      n.mem_read  = 1'b0;
      n.mem_write = 1'b0;
      n.reg_write = 1'b0;
    end else begin
      n.valid      = 1'b1;
      n.mem_read   = mem_read;
      n.mem_write  = mem_write;
      n.reg_write  = reg_write;
      n.overflow   = model_ovf(alu_op, operand_a, operand_b);
      n.dest_reg   = dest_reg;
      n.store_data = store_data;
      n.result     = model_res(alu_op, operand_a, operand_b);
    end
    return n;
  endfunction

  function automatic logic model_taken();
    logic [15:0] r;
    r = model_res(alu_op, operand_a, operand_b);
    return !reset && in_valid && !flush && !stall && is_branch && r[0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [38:0] exp_q[$];

  always @(posedge clk) begin
    exp_q.push_back(model_next(m_reg));
    m_reg <= model_next(m_reg);
  end

  // Inputs change 1 time unit after the rising edge, so the falling edge
  // sees settled inputs and settled registered outputs.
  always @(negedge clk) begin
    em_t act;
    check("fwd_result", 39'(fwd_result), 39'(model_res(alu_op, operand_a, operand_b)));
    check("branch_taken", 39'(branch_taken), 39'(model_taken()));
    check("redirect_pc", 39'(redirect_pc), 39'(branch_target));
    if (exp_q.size() > 0) begin
      act = {ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write, ex_mem_reg_write,
             ex_mem_overflow, ex_mem_dest_reg, ex_mem_store_data, ex_mem_result};
      check("ex_mem", act, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic br, input logic [15:0] tgt);
    in_valid      = v;
    alu_op        = op;
    operand_a     = a;
    operand_b     = b;
    is_branch     = br;
    branch_target = tgt;
    store_data    = a ^ b;
    dest_reg      = op[1:0];
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = !br;
    stall         = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [15:0] vec_a [6];
  logic [15:0] vec_b [6];

  initial begin
    vec_a = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'h0001};
    vec_b = '{16'h0000, 16'h0001, 16'h8000, 16'h0001, 16'h1234, 16'hFFFF};

    reset = 1'b1;
    drive(1'b1, 4'd0, 16'h0001, 16'h0002, 1'b0, 16'h0000);
    m_reg = '0;
    tick(); tick();
    reset = 1'b0;

    drive(1'b1, 4'd0, 16'h0003, 16'h0004, 1'b0, 16'h0000);
    tick();
    check("add_3_4", 39'(ex_mem_result), 39'(16'h0007));
    check("add_valid", 39'(ex_mem_valid), 39'(1'b1));

    // Reset while a taken branch sits in EX.
    reset = 1'b1;
    drive(1'b1, 4'd7, 16'h0007, 16'h0007, 1'b1, 16'h0010);
    #1 check("taken_in_reset", 39'(branch_taken), 39'(1'b0));
    tick();
    check("reset_ex_mem", {ex_mem_valid, ex_mem_reg_write, ex_mem_result, ex_mem_store_data},
          39'(0));
    reset = 1'b0;

    drive(1'b1, 4'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h0000); tick();
    check("add_ovf_res", 39'(ex_mem_result), 39'(16'h8000));
    check("add_ovf_flag", 39'(ex_mem_overflow), 39'(1'b1));
    drive(1'b1, 4'd1, 16'h0005, 16'h0007, 1'b0, 16'h0000); tick();
    check("sub_res", 39'(ex_mem_result), 39'(16'hFFFE));
    check("sub_ovf", 39'(ex_mem_overflow), 39'(1'b0));
    drive(1'b1, 4'd13, 16'h8004, 16'h0000, 1'b0, 16'h0000); tick();
    check("shr", 39'(ex_mem_result), 39'(16'hC002));
    drive(1'b1, 4'd12, 16'h8001, 16'h0000, 1'b0, 16'h0000); tick();
    check("shl", 39'(ex_mem_result), 39'(16'h0002));
    drive(1'b1, 4'd14, 16'h0001, 16'h0000, 1'b0, 16'h0000); tick();
    check("neg_1", 39'(ex_mem_result), 39'(16'hFFFF));
    drive(1'b1, 4'd11, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000); tick();
    check("op_1011", 39'(ex_mem_result), 39'(16'h0000));
    drive(1'b1, 4'd14, 16'h8000, 16'h0000, 1'b0, 16'h0000); tick();
    check("neg_min", {ex_mem_overflow, ex_mem_result}, {1'b0, 16'h8000});

    // BEQ taken, BGZ on a negative value not taken.
    drive(1'b1, 4'd7, 16'h1234, 16'h1234, 1'b1, 16'h0040);
    #1 check("beq_taken", {branch_taken, redirect_pc}, {1'b1, 16'h0040});
    tick();
    check("beq_no_regwrite", 39'(ex_mem_reg_write), 39'(1'b0));
    drive(1'b1, 4'd8, 16'hFFFF, 16'h0000, 1'b1, 16'h0050);
    #1 check("bgz_not_taken", 39'(branch_taken), 39'(1'b0));
    tick();

    // Taken BNE held under a 3-cycle stall.
    drive(1'b1, 4'd0, 16'h0100, 16'h0023, 1'b0, 16'h0000); tick();
    drive(1'b1, 4'd6, 16'h0001, 16'h0002, 1'b1, 16'h0080);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("bne_stalled", 39'(branch_taken), 39'(1'b0));
      tick();
      check("stall_hold", {ex_mem_valid, ex_mem_result}, {1'b1, 16'h0123});
    end
    stall = 1'b0;
    #1 check("bne_released", 39'(branch_taken), 39'(1'b1));
    tick();
    check("bne_result", 39'(ex_mem_result), 39'(16'h0001));
    drive(1'b1, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    #1 check("bne_once", 39'(branch_taken), 39'(1'b0));
    tick();

    // Flushed store.
    drive(1'b1, 4'd0, 16'h0010, 16'h0002, 1'b0, 16'h0000);
    mem_write  = 1'b1;
    reg_write  = 1'b0;
    store_data = 16'hBEEF;
    flush      = 1'b1;
    tick();
    check("flush_swd", {ex_mem_valid, ex_mem_mem_write}, 39'(0));

    // Stall and flush together: EX/MEM keeps the prior instruction.
    drive(1'b1, 4'd10, 16'h0000, 16'h5555, 1'b0, 16'h0000); tick();
    drive(1'b1, 4'd2, 16'hAAAA, 16'h0000, 1'b0, 16'h0000);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    check("stall_flush_hold", {ex_mem_valid, ex_mem_result}, {1'b1, 16'h5555});

    drive(1'b0, 4'd0, 16'h0001, 16'h0001, 1'b0, 16'h0000); tick();
    check("bubble", 39'(ex_mem_valid), 39'(1'b0));

    // Every op code across a set of operand pairs, checked by the model.
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 6; k++) begin
        drive(1'b1, 4'(op), vec_a[k], vec_b[k], (op >= 6 && op <= 9), 16'(op * 16 + k));
        mem_read = (k == 2);
        tick();
      end
    end

    drive(1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_ex_stage.md
# alu_ex_stage

Execute stage of the pipelined TSC CPU. Consumes the 4-bit ALU operation code produced by the ALU control decoder together with the ID/EX operands, computes the 16-bit result and branch condition, and registers everything the MEM stage needs into the EX/MEM pipeline register. Branch resolution happens here: a taken branch is reported to the fetch/hazard logic in the same cycle the instruction occupies EX.

## Interface
- WORD_WIDTH, 16, datapath width
- REG_ADDR_WIDTH, 2, register-file address width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  ID/EX slot holds a real instruction
- stall  input  1  MEM stage cannot accept; hold EX/MEM register
- flush  input  1  squash the instruction currently in EX
- alu_op  input  4  operation code from the ALU control decoder
- operand_a  input  WORD_WIDTH  forwarded source A
- operand_b  input  WORD_WIDTH  forwarded source B or extended immediate
- store_data  input  WORD_WIDTH  data for SWD
- dest_reg  input  REG_ADDR_WIDTH  write-back register
- mem_read, mem_write, reg_write, is_branch  input  1 each  control bits from ID
- branch_target  input  WORD_WIDTH  precomputed PC+1+offset
- branch_taken  output  1  combinational; redirect fetch this cycle
- redirect_pc  output  WORD_WIDTH  equals branch_target
- fwd_result  output  WORD_WIDTH  combinational ALU result for EX-to-EX forwarding
- ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write, ex_mem_reg_write  output  1 each  registered
- ex_mem_result, ex_mem_store_data  output  WORD_WIDTH  registered
- ex_mem_dest_reg  output  REG_ADDR_WIDTH  registered
- ex_mem_overflow  output  1  registered signed-overflow flag of ADD/SUB

## Operation
- alu_op encoding: 0000 A+B; 0001 A-B; 0010 pass A; 0011 ~A; 0100 A&B; 0101 A|B; 0110 A!=B; 0111 A==B; 1000 A>0 (signed); 1001 A<0 (signed); 1010 pass B; 1100 A<<1 (zero fill); 1101 A>>>1 (arithmetic); 1110 -A (two's complement). 1011, 1111 → result 0.
- Compare ops (0110–1001) produce 16'h0001 true / 16'h0000 false; condition = result[0].
- Arithmetic wraps modulo 2^16; overflow = signed overflow for 0000/0001, else 0; 1110 on 16'h8000 gives 16'h8000, overflow 0.
- live = in_valid & ~flush & ~stall.
- branch_taken = live & is_branch & result[0]; never asserted while stalled or flushed, so each branch redirects exactly once.
- EX/MEM register update each clock: reset → all ex_mem_* = 0; else stall → hold all; else flush or ~in_valid → ex_mem_valid, mem_read, mem_write, reg_write = 0 (data fields don't-care, hold); else load computed values, ex_mem_valid = 1.
- Stall and flush together: stall wins for EX/MEM (hold); incoming instruction is dropped; upstream must not replay it.
- Branches write no register: ID drives reg_write = 0; stage passes it through unchanged.

## Timing
- Combinational path alu_op/operands → fwd_result, branch_taken within one cycle.
- Latency: instruction in EX in cycle N appears on ex_mem_* after edge N+1.
- Reset mid-operation: at the reset edge all ex_mem_* clear; branch_taken forced 0 while reset high.
- Hold under stall is indefinite; no output changes until stall deasserts.

## Structure
- Operation codes as named constants in shared header alu_ops.v (ALU_ADD … ALU_NEG), also used by the ALU control decoder.
- One combinational sub-module alu (alu_op, a, b → result, overflow); alu_ex_stage holds branch logic and the EX/MEM register.

## Test plan
- Reset: assert reset with in_valid=1 ADD → all ex_mem_* = 0 next cycle, branch_taken=0.
- ADD 16'h7FFF+16'h0001 → ex_mem_result 16'h8000, overflow 1; SUB 16'h0005-16'h0007 → 16'hFFFE, overflow 0.
- SHR 16'h8004 → 16'hC002; SHL 16'h8001 → 16'h0002; NEG 16'h0001 → 16'hFFFF; op 1011 → 0.
- BEQ A=B=16'h1234, is_branch=1, target 16'h0040 → branch_taken=1, redirect_pc 16'h0040 same cycle; BGZ A=16'hFFFF → not taken.
- Stall 3 cycles with taken BNE in EX → branch_taken 0 throughout, ex_mem_* unchanged; release → branch_taken 1 for exactly one cycle.
- flush with valid SWD → next cycle ex_mem_valid=0, mem_write=0; stall+flush together → EX/MEM holds prior instruction.
